// File: rtl/frame_reader_if.sv
// Memory-arbiter read channel and display pop channel of the frame reader.
// The master side is the frame reader; the slave side is the arbiter plus
// the display pipeline.
interface frame_reader_if #(
    parameter int LOG_WIDTH  = 10,
    parameter int LOG_HEIGHT = 9,
    parameter int LOG_TRUNC  = 18,
    parameter int LOG_MEM    = 36
);
    logic                  fr_flag;
    logic [LOG_WIDTH-1:0]  fr_x;
    logic [LOG_HEIGHT-1:0] fr_y;
    logic                  done_fr;
    logic [LOG_MEM-1:0]    fr_pixel_read;
    logic                  fr_rvalid;
    logic                  disp_req;
    logic [LOG_TRUNC-1:0]  disp_pixel;
    logic                  disp_valid;

    modport master (
        output fr_flag, fr_x, fr_y, disp_pixel, disp_valid,
        input  done_fr, fr_pixel_read, fr_rvalid, disp_req
    );

    modport slave (
        input  fr_flag, fr_x, fr_y, disp_pixel, disp_valid,
        output done_fr, fr_pixel_read, fr_rvalid, disp_req
    );
endinterface

// File: rtl/frame_reader.sv
// Frame reader: scans the packed frame buffer in raster order, keeps at most
// DEPTH words in flight or buffered, and unpacks each returned 36-bit word
// into two 18-bit pixels (upper half first) for the display pipeline.
module frame_reader #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int LOG_WIDTH  = 10,
    parameter int LOG_HEIGHT = 9,
    parameter int LOG_TRUNC  = 18,
    parameter int LOG_MEM    = 36,
    parameter int DEPTH      = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_start,
    output logic           underflow,
    frame_reader_if.master bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LOG_WIDTH-1:0]  X_LAST    = LOG_WIDTH'(WIDTH - 2);
    localparam logic [LOG_HEIGHT-1:0] Y_LAST    = LOG_HEIGHT'(HEIGHT - 1);
    localparam logic [CNT_W:0]        OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Pick one pixel out of a packed word; the even-x pixel sits in the upper half.
    function automatic logic [LOG_TRUNC-1:0] select_half(
        input logic [LOG_MEM-1:0] word,
        input logic               lower
    );
        logic [LOG_TRUNC-1:0] res;
        if (lower) begin
            res = word[LOG_TRUNC-1:0];
        end else begin
            res = word[LOG_MEM-1 -: LOG_TRUNC];
        end
        return res;
    endfunction

    state_t                state_r, state_s;
    logic [LOG_WIDTH-1:0]  x_r, x_s;
    logic [LOG_HEIGHT-1:0] y_r, y_s;
    logic [CNT_W-1:0]      count_r, count_s;
    logic [CNT_W-1:0]      outstanding_r, outstanding_s;
    logic [CNT_W-1:0]      discard_r, discard_s;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic                  half_r;
    logic [LOG_MEM-1:0]    mem_r [DEPTH];
    logic [LOG_TRUNC-1:0]  pixel_r, pixel_s;
    logic                  valid_r, valid_s;
    logic                  underflow_r, underflow_s;

    logic [CNT_W:0]        occupancy_s;
    logic                  flag_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  pop_word_s;

    // Request FSM: idle until the first frame_start, then scan forever.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: state_s = ST_SCAN;
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake qualifiers; words in flight count against the FIFO so a return never overflows it.
    always_comb begin
        occupancy_s = {1'b0, count_r} + {1'b0, outstanding_r};
        flag_s      = (state_r == ST_SCAN) && !frame_start && (occupancy_s < OCC_LIMIT);
        accept_s    = flag_s && bus.done_fr;
        drop_s      = bus.fr_rvalid && (discard_r != '0);
        push_s      = bus.fr_rvalid && (discard_r == '0) && !frame_start;
        pop_s       = bus.disp_req && (count_r != '0) && !frame_start;
        pop_word_s  = pop_s && half_r;
    end

    // Next values of the in-flight, discard and FIFO occupancy counters.
    always_comb begin
        outstanding_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(bus.fr_rvalid);
        if (frame_start) begin
            // Everything still in flight after this cycle belongs to the old frame.
            discard_s = outstanding_r - CNT_W'(bus.fr_rvalid);
            count_s   = '0;
        end else begin
            discard_s = discard_r - CNT_W'(drop_s);
            count_s   = count_r + CNT_W'(push_s) - CNT_W'(pop_word_s);
        end
    end

    // Raster address advance: two pixels per word, wrapping line and frame.
    always_comb begin
        x_s = x_r;
        y_s = y_r;
        if (frame_start) begin
            x_s = '0;
            y_s = '0;
        end else if (accept_s) begin
            if (x_r == X_LAST) begin
                x_s = '0;
                if (y_r == Y_LAST) begin
                    y_s = '0;
                end else begin
                    y_s = y_r + LOG_HEIGHT'(1);
                end
            end else begin
                x_s = x_r + LOG_WIDTH'(2);
                y_s = y_r;
            end
        end else begin
            x_s = x_r;
            y_s = y_r;
        end
    end

    // Display output: a pop shows the selected half; an empty pop sets the sticky underflow.
    always_comb begin
        pixel_s     = pixel_r;
        valid_s     = 1'b0;
        underflow_s = underflow_r;
        if (pop_s) begin
            valid_s = 1'b1;
            pixel_s = select_half(mem_r[rd_ptr_r], half_r);
        end else if (bus.disp_req) begin
            underflow_s = 1'b1;
        end else begin
            underflow_s = underflow_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r           <= '0;
            y_r           <= '0;
            count_r       <= '0;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            x_r           <= x_s;
            y_r           <= y_s;
            count_r       <= count_s;
            outstanding_r <= outstanding_s;
            discard_r     <= discard_s;
        end
    end

    // FIFO storage, pointers and half-select; frame_start empties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            half_r   <= 1'b0;
        end else if (frame_start) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            half_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.fr_pixel_read;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                half_r <= ~half_r;
            end
            if (pop_word_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_r     <= '0;
            valid_r     <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pixel_r     <= pixel_s;
            valid_r     <= valid_s;
            underflow_r <= underflow_s;
        end
    end

    assign bus.fr_flag    = flag_s;
    assign bus.fr_x       = x_r;
    assign bus.fr_y       = y_r;
    assign bus.disp_pixel = pixel_r;
    assign bus.disp_valid = valid_r;
    assign underflow      = underflow_r;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model of
// the scan position, requests in flight and buffered pixels.
module tb_frame_reader;

    localparam int W     = 8;
    localparam int H     = 3;
    localparam int LW    = 10;
    localparam int LH    = 9;
    localparam int LT    = 18;
    localparam int LM    = 36;
    localparam int DEPTH = 4;
    localparam int WPL   = W / 2;
    localparam int TOTAL = WPL * H;

    logic clock       = 1'b0;
    logic reset       = 1'b0;
    logic frame_start = 1'b0;
    logic underflow;

    frame_reader_if #(.LOG_WIDTH(LW), .LOG_HEIGHT(LH), .LOG_TRUNC(LT), .LOG_MEM(LM)) bus ();

    frame_reader #(
        .WIDTH(W), .HEIGHT(H), .LOG_WIDTH(LW), .LOG_HEIGHT(LH),
        .LOG_TRUNC(LT), .LOG_MEM(LM), .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .frame_start(frame_start),
        .underflow(underflow),
        .bus(bus.master)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // reference model
    bit            m_scan;
    int            m_idx;
    bit            m_inflight[$];   // one entry per accepted request; 1 = belongs to a flushed frame
    logic [LT-1:0] m_pix[$];        // pixels buffered, in display order
    logic          m_valid;
    logic [LT-1:0] m_pix_out;
    logic          m_uf;

    // sampled DUT outputs
    logic          s_flag;
    logic [LW-1:0] s_x;
    logic [LH-1:0] s_y;
    logic          s_valid;
    logic [LT-1:0] s_pix;
    logic          s_uf;

    typedef struct {
        logic          fs;
        logic          gnt;
        logic          rv;
        logic [LM-1:0] data;
        logic          dreq;
        logic          e_flag;
        int            e_x;
        int            e_y;
        logic          e_valid;
        logic [LT-1:0] e_pix;
        logic          e_uf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_scan = 1'b0;
        m_idx  = 0;
        m_inflight.delete();
        m_pix.delete();
        m_valid   = 1'b0;
        m_pix_out = '0;
        m_uf      = 1'b0;
    endfunction

    // One clock: drive inputs, check request side before the edge, advance model, check display after.
    task automatic run_cycle(input logic fs, input logic gnt, input logic rv,
                             input logic [LM-1:0] data, input logic dreq);
        int   words;
        logic e_flag;
        bit   stale;
        frame_start       = fs;
        bus.done_fr       = gnt;
        bus.fr_rvalid     = rv;
        bus.fr_pixel_read = data;
        bus.disp_req      = dreq;
        @(negedge clock);
        s_flag = bus.fr_flag;
        s_x    = bus.fr_x;
        s_y    = bus.fr_y;
        words  = (m_pix.size() + 1) / 2;
        e_flag = m_scan && !fs && ((words + m_inflight.size()) < DEPTH);
        chk("fr_flag", 64'(s_flag), 64'(e_flag));
        chk("fr_x", 64'(s_x), 64'(2 * (m_idx % WPL)));
        chk("fr_y", 64'(s_y), 64'(m_idx / WPL));

        if (dreq && !fs && (m_pix.size() > 0)) begin
            m_valid   = 1'b1;
            m_pix_out = m_pix.pop_front();
        end else begin
            m_valid = 1'b0;
            if (dreq) m_uf = 1'b1;
        end
        if (rv && (m_inflight.size() > 0)) begin
            stale = m_inflight.pop_front();
            if (!stale && !fs) begin
                m_pix.push_back(data[LM-1:LT]);
                m_pix.push_back(data[LT-1:0]);
            end
        end
        if (fs) begin
            m_pix.delete();
            foreach (m_inflight[k]) m_inflight[k] = 1'b1;
            m_idx  = 0;
            m_scan = 1'b1;
        end
        if (e_flag && gnt) begin
            m_inflight.push_back(1'b0);
            m_idx = (m_idx + 1) % TOTAL;
        end

        @(posedge clock);
        #1;
        s_valid = bus.disp_valid;
        s_pix   = bus.disp_pixel;
        s_uf    = underflow;
        chk("disp_valid", 64'(s_valid), 64'(m_valid));
        chk("disp_pixel", 64'(s_pix), 64'(m_pix_out));
        chk("underflow", 64'(s_uf), 64'(m_uf));
        frame_start   = 1'b0;
        bus.done_fr   = 1'b0;
        bus.fr_rvalid = 1'b0;
        bus.disp_req  = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        logic [LM-1:0] w_aa;
        logic [LM-1:0] w_ff;
        w_aa = {18'h2AAAA, 18'h15555};
        w_ff = {18'h3FFFF, 18'h00000};

        //              fs    gnt   rv    data        dreq  flag  x  y  valid pix         uf
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 36'h0, 1'b0, 1'b0, 0, 0, 1'b0, 18'h00000, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 0, 0, 1'b0, 18'h00000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 2, 0, 1'b0, 18'h00000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 4, 0, 1'b0, 18'h00000, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b1, 6, 0, 1'b0, 18'h00000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 36'h0, 1'b0, 1'b0, 0, 1, 1'b0, 18'h00000, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, w_aa,  1'b0, 1'b0, 0, 1, 1'b0, 18'h00000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 36'h0, 1'b1, 1'b0, 0, 1, 1'b1, 18'h2AAAA, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 36'h0, 1'b1, 1'b0, 0, 1, 1'b1, 18'h15555, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 36'h0, 1'b0, 1'b1, 0, 1, 1'b0, 18'h15555, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 36'h0, 1'b1, 1'b1, 0, 1, 1'b0, 18'h15555, 1'b1};

        bus.done_fr       = 1'b0;
        bus.fr_rvalid     = 1'b0;
        bus.fr_pixel_read = '0;
        bus.disp_req      = 1'b0;
        model_reset();

        // reset state
        #12;
        chk("rst_flag", 64'(bus.fr_flag), 64'(0));
        chk("rst_x", 64'(bus.fr_x), 64'(0));
        chk("rst_y", 64'(bus.fr_y), 64'(0));
        chk("rst_pix", 64'(bus.disp_pixel), 64'(0));
        chk("rst_valid", 64'(bus.disp_valid), 64'(0));
        chk("rst_uf", 64'(underflow), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // basic fetch, unpack and first underflow from the vector table
        for (int i = 0; i < 11; i++) begin
            run_cycle(tbl[i].fs, tbl[i].gnt, tbl[i].rv, tbl[i].data, tbl[i].dreq);
            chk($sformatf("tbl%0d_flag", i), 64'(s_flag), 64'(tbl[i].e_flag));
            chk($sformatf("tbl%0d_x", i), 64'(s_x), 64'(tbl[i].e_x));
            chk($sformatf("tbl%0d_y", i), 64'(s_y), 64'(tbl[i].e_y));
            chk($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pix", i), 64'(s_pix), 64'(tbl[i].e_pix));
            chk($sformatf("tbl%0d_uf", i), 64'(s_uf), 64'(tbl[i].e_uf));
        end

        // underflow stays set through valid pops
        run_cycle(1'b0, 1'b0, 1'b1, {18'h12345, 18'h0ABCD}, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        chk("uf_sticky_valid0", 64'(s_valid), 64'(1));
        chk("uf_sticky_pix0", 64'(s_pix), 64'(18'h12345));
        chk("uf_sticky0", 64'(s_uf), 64'(1));
        run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        chk("uf_sticky_pix1", 64'(s_pix), 64'(18'h0ABCD));
        chk("uf_sticky1", 64'(s_uf), 64'(1));

        // flush with two stale returns outstanding
        run_cycle(1'b1, 1'b1, 1'b0, 36'h0, 1'b0);
        chk("flush_flag_hold", 64'(s_flag), 64'(0));
        run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
        chk("flush_flag", 64'(s_flag), 64'(1));
        chk("flush_x", 64'(s_x), 64'(0));
        chk("flush_y", 64'(s_y), 64'(0));
        run_cycle(1'b0, 1'b0, 1'b1, 36'h1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1, 36'h1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1, w_ff, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        chk("flush_pop_valid", 64'(s_valid), 64'(1));
        chk("flush_pop_pix", 64'(s_pix), 64'(18'h3FFFF));
        run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        chk("flush_pop2_pix", 64'(s_pix), 64'(18'h00000));

        // frame wrap: walk to the last word, then two back-to-back grants
        run_cycle(1'b1, 1'b0, 1'b0, 36'h0, 1'b0);
        for (int i = 0; i < TOTAL - 1; i++) begin
            r64 = {$urandom(), $urandom()};
            run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
            run_cycle(1'b0, 1'b0, 1'b1, r64[LM-1:0], 1'b0);
            run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
            run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        end
        run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
        chk("wrap_last_flag", 64'(s_flag), 64'(1));
        chk("wrap_last_x", 64'(s_x), 64'(W - 2));
        chk("wrap_last_y", 64'(s_y), 64'(H - 1));
        run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
        chk("wrap_first_flag", 64'(s_flag), 64'(1));
        chk("wrap_first_x", 64'(s_x), 64'(0));
        chk("wrap_first_y", 64'(s_y), 64'(0));
        for (int i = 0; i < 2; i++) begin
            r64 = {$urandom(), $urandom()};
            run_cycle(1'b0, 1'b0, 1'b1, r64[LM-1:0], 1'b0);
        end
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);

        // asynchronous reset mid-scan at fr_x=6 with two outstanding
        run_cycle(1'b1, 1'b0, 1'b0, 36'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1, {18'h00777, 18'h00888}, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 36'h0, 1'b1);
        #2;
        chk("pre_rst_x", 64'(bus.fr_x), 64'(6));
        reset = 1'b0;
        #1;
        chk("mid_rst_flag", 64'(bus.fr_flag), 64'(0));
        chk("mid_rst_x", 64'(bus.fr_x), 64'(0));
        chk("mid_rst_y", 64'(bus.fr_y), 64'(0));
        chk("mid_rst_pix", 64'(bus.disp_pixel), 64'(0));
        chk("mid_rst_valid", 64'(bus.disp_valid), 64'(0));
        chk("mid_rst_uf", 64'(underflow), 64'(0));
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 36'h0, 1'b0);
            chk("post_rst_flag", 64'(s_flag), 64'(0));
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic fs, gnt, rv, dreq;
            r64  = {$urandom(), $urandom()};
            fs   = (i == 0) || ($urandom_range(0, 99) == 0);
            gnt  = ($urandom_range(0, 9) < 7);
            rv   = (m_inflight.size() > 0) && ($urandom_range(0, 9) < 6);
            dreq = ($urandom_range(0, 1) == 1);
            run_cycle(fs, gnt, rv, r64[LM-1:0], dreq);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
